// File: rtl/vec_pkg.sv
// vec_pkg: lane-slicing helpers and packer state type shared by the
// vector packer and the reduction tree.
package vec_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } vp_state_t;

  // Low bit of lane k in a lane-packed word of w-bit elements.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  // Width needed to hold an element count from 0 to n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vec_pack_out.sv
// vec_pack_out: output register of the packer. A load always wins over a
// drain, so load+drain in one cycle keeps the valid flag up with new data.
module vec_pack_out #(
  parameter int W_DATA = 128,
  parameter int W_CNT  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_load,
  input  logic [W_DATA-1:0] i_data,
  input  logic [W_CNT-1:0]  i_count,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_DATA-1:0] o_data,
  output logic [W_CNT-1:0]  o_count
);

  logic              r_valid;
  logic [W_DATA-1:0] r_data;
  logic [W_CNT-1:0]  r_count;

  // Output slot: capture a completed vector, drop valid when consumed, else hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_count <= i_count;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/vec_pack.sv
// vec_pack: assembles N W-bit stream elements into one lane-packed vector.
// Fill buffer + lane index + FILL/HOLD FSM live here; the output register
// is vec_pack_out. Short vectors (in_last) are zero-padded.
module vec_pack
  import vec_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int CW = count_width(N)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [W*N-1:0] out_data,
  output logic [CW-1:0]  out_count,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  vp_state_t      r_state;
  vp_state_t      w_state_next;
  logic           r_in_ready;
  logic           w_in_ready_next;
  logic [W*N-1:0] r_buf;
  logic [W*N-1:0] w_merged;
  logic [W*N-1:0] w_load_data;
  logic [CW-1:0]  r_idx;
  logic [CW-1:0]  w_idx_inc;
  logic [CW-1:0]  w_load_count;
  logic           w_accept;
  logic           w_final;
  logic           w_slot_free;
  logic           w_load;

  // in_ready is high only in FILL, so w_final also implies FILL.
  assign w_accept    = in_valid & r_in_ready;
  assign w_final     = w_accept & (in_last | (r_idx == LAST_IDX));
  assign w_slot_free = ~out_valid | out_ready;
  assign w_idx_inc   = r_idx + CW'(1'b1);
  assign in_ready    = r_in_ready;

  // Fill buffer with the incoming element written into lane r_idx.
  always_comb begin
    w_merged = r_buf;
    for (int k = 0; k < N; k++) begin
      if (r_idx == CW'(k)) begin
        w_merged[lane_lo(k, W) +: W] = in_data;
      end else begin
        w_merged[lane_lo(k, W) +: W] = r_buf[lane_lo(k, W) +: W];
      end
    end
  end

  // FSM state register; in_ready is registered as the decode of the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= FILL;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  // FSM next state: park in HOLD when a vector completes into a busy slot.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (w_final && !w_slot_free) begin
          w_state_next = HOLD;
        end else begin
          w_state_next = FILL;
        end
      end
      HOLD: begin
        if (w_slot_free) begin
          w_state_next = FILL;
        end else begin
          w_state_next = HOLD;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // FSM outputs: when to load the output slot and from where.
  always_comb begin
    w_load       = 1'b0;
    w_load_data  = r_buf;
    w_load_count = w_idx_inc;
    case (r_state)
      FILL: begin
        w_load      = w_final & w_slot_free;
        w_load_data = w_merged;
      end
      HOLD: begin
        w_load      = w_slot_free;
        w_load_data = r_buf;
      end
      default: begin
        w_load      = 1'b0;
        w_load_data = r_buf;
      end
    endcase
    if (w_state_next == FILL) begin
      w_in_ready_next = 1'b1;
    end else begin
      w_in_ready_next = 1'b0;
    end
  end

  // Fill buffer and lane index: clear on handoff, advance on a non-final
  // accept, keep the index on a final accept that must wait in HOLD so the
  // count is still r_idx+1 when the slot frees up.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_accept && !w_final) begin
      r_buf <= w_merged;
      r_idx <= w_idx_inc;
    end else if (w_final) begin
      r_buf <= w_merged;
      r_idx <= r_idx;
    end else begin
      r_buf <= r_buf;
      r_idx <= r_idx;
    end
  end

  vec_pack_out #(
    .W_DATA (W * N),
    .W_CNT  (CW)
  ) u_out (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_count (w_load_count),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_count (out_count)
  );

endmodule

// File: tb/tb_vec_pack.sv
// tb_vec_pack: directed table for vec_pack (N=4, W=8) plus hand-written
// stream, reset and N=1 sequences.
module tb_vec_pack;

  logic        clock;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  d1;
  logic        v1;
  logic        l1;
  logic        ir1;
  logic [7:0]  od1;
  logic [0:0]  oc1;
  logic        ov1;
  logic        or1;

  int checks = 0;
  int errors = 0;

  vec_pack #(.N(4), .W(8)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  vec_pack #(.N(1), .W(8)) dut1 (
    .clock     (clock),
    .resetn    (resetn),
    .in_data   (d1),
    .in_valid  (v1),
    .in_last   (l1),
    .in_ready  (ir1),
    .out_data  (od1),
    .out_count (oc1),
    .out_valid (ov1),
    .out_ready (or1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic        ord;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        eir;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic l, input logic [7:0] d,
                              input logic ord, input logic ev, input logic [31:0] ed,
                              input logic [2:0] ec, input logic eir);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.ord = ord;
    r.ev = ev; r.ed = ed; r.ec = ec; r.eir = eir;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t tv[$];

  initial begin
    int sent;
    int got;
    int cyc;
    logic acc;
    logic [31:0] expv;

    resetn = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    d1 = 8'h00; v1 = 1'b0; l1 = 1'b0; or1 = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_count", {61'd0, out_count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_n1_valid", {63'd0, ov1}, 64'd0);

    // table: full vector, short vector, last at lane N-1, backpressure/HOLD
    tv.push_back(mk(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 32'h44332211, 3'd4, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 32'h0000A2A1, 3'd2, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 32'h000000BB, 3'd1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hC1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hC2, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'hC4, 1'b1, 1'b1, 32'hC4C3C2C1, 3'd4, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h08070605, 3'd4, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 32'h00000099, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1));

    for (int i = 0; i < tv.size(); i++) begin
      in_valid = tv[i].v; in_last = tv[i].l; in_data = tv[i].d; out_ready = tv[i].ord;
      step();
      chk($sformatf("row%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tv[i].ev});
      chk($sformatf("row%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tv[i].eir});
      if (tv[i].ev) begin
        chk($sformatf("row%0d_out_data", i), {32'd0, out_data}, {32'd0, tv[i].ed});
        chk($sformatf("row%0d_out_count", i), {61'd0, out_count}, {61'd0, tv[i].ec});
      end
    end
    in_valid = 1'b0; in_last = 1'b0;

    // sustained stream with random gaps, consumer always ready
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while ((sent < 100 || got < 25) && cyc < 2000) begin
      in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_data  = 8'(sent * 3 + 1);
      in_last  = 1'b0;
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) sent++;
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (out_valid) begin
        for (int j = 0; j < 4; j++) expv[j*8 +: 8] = 8'((got * 4 + j) * 3 + 1);
        chk($sformatf("stream_vec%0d_data", got), {32'd0, out_data}, {32'd0, expv});
        chk($sformatf("stream_vec%0d_count", got), {61'd0, out_count}, 64'd4);
        got++;
      end
    end
    in_valid = 1'b0;
    chk("stream_timeout", {63'd0, (cyc < 2000)}, 64'd1);
    chk("stream_vec_total", 64'(got), 64'd25);
    step();
    chk("stream_idle_valid", {63'd0, out_valid}, 64'd0);

    // reset mid-vector with a held output vector
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_last = 1'b0;
      in_data = (j < 4) ? 8'(j + 1) : ((j == 4) ? 8'h55 : 8'h66);
      step();
    end
    in_valid = 1'b0;
    chk("prerst_out_valid", {63'd0, out_valid}, 64'd1);
    resetn = 1'b0;
    #2;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data", {32'd0, out_data}, 64'd0);
    chk("midrst_out_count", {61'd0, out_count}, 64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("postrst_out_valid", {63'd0, out_valid}, 64'd1);
    chk("postrst_out_data", {32'd0, out_data}, 64'h00000077);
    chk("postrst_out_count", {61'd0, out_count}, 64'd1);
    step();
    chk("postrst_drain", {63'd0, out_valid}, 64'd0);

    // N=1: every accept is final
    or1 = 1'b1; v1 = 1'b1; l1 = 1'b0; d1 = 8'h5A;
    step();
    chk("n1_a_valid", {63'd0, ov1}, 64'd1);
    chk("n1_a_data", {56'd0, od1}, 64'h5A);
    chk("n1_a_count", {63'd0, oc1}, 64'd1);
    l1 = 1'b1; d1 = 8'h5B;
    step();
    chk("n1_b_data", {56'd0, od1}, 64'h5B);
    chk("n1_b_count", {63'd0, oc1}, 64'd1);
    or1 = 1'b0; l1 = 1'b0; d1 = 8'h5C;
    step();
    chk("n1_hold_in_ready", {63'd0, ir1}, 64'd0);
    chk("n1_hold_data", {56'd0, od1}, 64'h5B);
    v1 = 1'b0; or1 = 1'b1;
    step();
    chk("n1_c_valid", {63'd0, ov1}, 64'd1);
    chk("n1_c_data", {56'd0, od1}, 64'h5C);
    chk("n1_c_in_ready", {63'd0, ir1}, 64'd1);
    step();
    chk("n1_drain", {63'd0, ov1}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
